// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - Hack CPU controller shared types, instruction field positions and jump rule.
package hack_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MREAD  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MWRITE = 3'd4
    } state_e;

    localparam int IBIT_CTYPE = 15;
    localparam int IBIT_A     = 12;
    localparam int COMP_HI    = 11;
    localparam int COMP_LO    = 6;
    localparam int DEST_A     = 5;
    localparam int DEST_D     = 4;
    localparam int DEST_M     = 3;
    localparam int JMP_HI     = 2;
    localparam int JMP_LO     = 0;

    // j[2]: jump if negative, j[1]: if zero, j[0]: if strictly positive.
    function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
        return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_cpu_ctrl.sv
// rtl/hack_cpu_ctrl.sv - Multi-cycle Hack CPU controller: fetch/decode/execute sequencing, A/D/PC registers.
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter logic [14:0] RESET_PC = 15'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [14:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [14:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [14:0] pc
);

    state_e      state_q, state_d;
    logic [14:0] pc_q, pc_d;
    logic [14:0] maddr_q, maddr_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] m_q, m_d;
    logic [15:0] r_q, r_d;
    logic [14:0] pc_inc;

    assign pc_inc    = pc_q + 15'd1;
    assign pc        = pc_q;
    assign imem_addr = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            maddr_q <= 15'd0;
            a_q     <= 16'd0;
            d_q     <= 16'd0;
            instr_q <= 16'd0;
            m_q     <= 16'd0;
            r_q     <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            maddr_q <= maddr_d;
            a_q     <= a_d;
            d_q     <= d_d;
            instr_q <= instr_d;
            m_q     <= m_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        maddr_d    = maddr_q;
        a_d        = a_q;
        d_d        = d_q;
        instr_d    = instr_q;
        m_d        = m_q;
        r_d        = r_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 15'd0;
        dmem_wdata = 16'd0;
        alu_x      = 16'd0;
        alu_y      = 16'd0;
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'd0;

        case (state_q)
            ST_FETCH: begin
                // Reset parks the FSM in FETCH; keep the request quiet until reset lifts.
                imem_req = rst_n;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!instr_q[IBIT_CTYPE]) begin
                    a_d     = {1'b0, instr_q[14:0]};
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end else if (instr_q[IBIT_A]) begin
                    state_d = ST_MREAD;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_MREAD: begin
                dmem_req  = 1'b1;
                dmem_addr = a_q[14:0];
                if (dmem_ack) begin
                    m_d     = dmem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_x = d_q;
                alu_y = instr_q[IBIT_A] ? m_q : a_q;
                {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = instr_q[COMP_HI:COMP_LO];
                r_d     = alu_out;
                maddr_d = a_q[14:0];
                // Jump target and store address both come from A before this instruction's write.
                pc_d = jump_taken(instr_q[JMP_HI:JMP_LO], alu_zr, alu_ng) ? a_q[14:0] : pc_inc;
                if (instr_q[DEST_A]) a_d = alu_out;
                if (instr_q[DEST_D]) d_d = alu_out;
                state_d = instr_q[DEST_M] ? ST_MWRITE : ST_FETCH;
            end
            ST_MWRITE: begin
                dmem_req   = 1'b1;
                dmem_we    = 1'b1;
                dmem_addr  = maddr_q;
                dmem_wdata = r_q;
                if (dmem_ack) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb/tb_hack_cpu_ctrl.sv - Self-checking bench for hack_cpu_ctrl against an instruction-level model.
module tb_hack_cpu_ctrl;

    localparam logic [14:0] RESET_PC_TB = 15'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack;
    logic [14:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata, dmem_rdata;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
    logic [14:0] pc;
    logic [5:0]  alu_ctl;

    always #5 clk = ~clk;

    hack_cpu_ctrl #(.RESET_PC(RESET_PC_TB)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng), .pc(pc)
    );

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    assign alu_ctl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
    assign alu_out = hack_alu(alu_x, alu_y, alu_ctl);
    assign alu_zr  = (alu_out == 16'h0000);
    assign alu_ng  = alu_out[15];

    logic [15:0] rom [0:32767];
    logic [15:0] ram [0:32767];

    int n_total = 0, n_pass = 0;
    int cyc = 0, last_fetch_cyc = 0, prev_lat = 0, waits_since = 0;
    int iwait = -1, dwait = -1, forced_dwait = -1, max_wait = 0;
    int fetch_cnt = 0, wr_cnt = 0, rd_cnt = 0, dreq_total = 0, dreq_cycles = 0, last_wr_cycles = 0;
    bit have_prev = 0, spurious = 0, dmem_hold = 0;
    logic [14:0] m_pc;
    logic [15:0] m_a, m_d;
    logic        exp_rd, exp_wr;
    logic [14:0] exp_rd_addr, exp_wr_addr, last_wr_addr, last_rd_addr;
    logic [15:0] exp_wr_data, last_wr_data, last_alu_y;
    logic [14:0] fetch_hist [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int pick_wait();
        return (max_wait == 0) ? 0 : int'($urandom_range(0, max_wait));
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC_TB; m_a = 16'h0; m_d = 16'h0;
        exp_rd = 1'b0; exp_wr = 1'b0; have_prev = 0;
        iwait = -1; dwait = -1; waits_since = 0; dreq_cycles = 0; dmem_hold = 0;
        fetch_cnt = 0; fetch_hist.delete();
    endtask

    // Whole-instruction semantics; bus traffic is queued as expectations for the compare step.
    task automatic model_exec(input logic [15:0] ins);
        logic [15:0] y, r;
        logic taken;
        if (!ins[15]) begin
            m_a = {1'b0, ins[14:0]};
            m_pc = m_pc + 15'd1;
            prev_lat = 2;
        end else begin
            y = ins[12] ? ram[m_a[14:0]] : m_a;
            r = hack_alu(m_d, y, ins[11:6]);
            taken = (ins[2] && $signed(r) < 0) || (ins[1] && r == 16'h0) || (ins[0] && $signed(r) > 0);
            exp_rd = ins[12]; exp_rd_addr = m_a[14:0];
            exp_wr = ins[3];  exp_wr_addr = m_a[14:0]; exp_wr_data = r;
            m_pc = taken ? m_a[14:0] : m_pc + 15'd1;
            if (ins[5]) m_a = r;
            if (ins[4]) m_d = r;
            prev_lat = 3 + int'(ins[12]) + int'(ins[3]);
        end
    endtask

    // Called just after a falling edge: compare, then drive acks for the coming rising edge.
    task automatic step();
        logic [15:0] ins;
        #1;
        cyc++;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (alu_ctl != 6'd0) last_alu_y = alu_y;
        if (imem_req) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("pc_out", pc, m_pc);
            if (iwait < 0) iwait = pick_wait();
            if (iwait == 0) begin
                ins = rom[imem_addr];
                imem_ack = 1'b1;
                imem_rdata = ins;
                fetch_hist.push_back(imem_addr);
                fetch_cnt++;
                if (have_prev) begin
                    chk("latency", cyc - last_fetch_cyc, prev_lat + waits_since);
                    chk("read_done", exp_rd, 1'b0);
                    chk("write_done", exp_wr, 1'b0);
                end
                have_prev = 1; last_fetch_cyc = cyc; waits_since = 0;
                model_exec(ins);
                iwait = -1;
            end else begin
                iwait--; waits_since++;
            end
        end else if (spurious && $urandom_range(0, 7) == 0) begin
            imem_ack = 1'b1; imem_rdata = 16'($urandom);
        end
        if (dmem_req) begin
            dreq_total++; dreq_cycles++;
            if (dmem_we) begin
                chk("wr_expected", exp_wr && !exp_rd, 1'b1);
                chk("wr_addr", dmem_addr, exp_wr_addr);
                chk("wr_data", dmem_wdata, exp_wr_data);
            end else begin
                chk("rd_expected", exp_rd, 1'b1);
                chk("rd_addr", dmem_addr, exp_rd_addr);
            end
            if (dmem_hold) begin
                waits_since++;
            end else begin
                if (dwait < 0) begin
                    dwait = (forced_dwait >= 0) ? forced_dwait : pick_wait();
                    forced_dwait = -1;
                end
                if (dwait == 0) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) begin
                        ram[dmem_addr] = dmem_wdata; exp_wr = 1'b0; wr_cnt++;
                        last_wr_addr = dmem_addr; last_wr_data = dmem_wdata; last_wr_cycles = dreq_cycles;
                    end else begin
                        dmem_rdata = ram[dmem_addr]; exp_rd = 1'b0; rd_cnt++; last_rd_addr = dmem_addr;
                    end
                    dreq_cycles = 0; dwait = -1;
                end else begin
                    dwait--; waits_since++;
                end
            end
        end else if (spurious && $urandom_range(0, 7) == 0) begin
            dmem_ack = 1'b1; dmem_rdata = 16'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic run_fetches(input int target, input int budget);
        int n = 0;
        while (fetch_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk("fetch_budget", fetch_cnt >= target, 1'b1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 16'h0; dmem_rdata = 16'h0;
        for (int i = 0; i < 32768; i++) begin rom[i] = 16'h0; ram[i] = 16'h0; end
        ram[3] = 16'h1234;
        rom[0]  = 16'h0005; rom[1]  = 16'hEC10; rom[2]  = 16'h0007; rom[3]  = 16'hE7C8;
        rom[4]  = 16'h0003; rom[5]  = 16'hFC10; rom[6]  = 16'h0014; rom[7]  = 16'hEA87;
        rom[20] = 16'h0005; rom[21] = 16'hEC10; rom[22] = 16'h000A; rom[23] = 16'hE301;
        rom[10] = 16'hEA90; rom[11] = 16'h000A; rom[12] = 16'hE301;
        rom[13] = 16'h0009; rom[14] = 16'hEC10; rom[15] = 16'h0004; rom[16] = 16'hE7FF;

        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_dmem_we", dmem_we, 1'b0);
        chk("rst_alu_x", alu_x, 16'h0);
        chk("rst_alu_y", alu_y, 16'h0);
        chk("rst_alu_ctl", alu_ctl, 6'h0);
        chk("rst_pc", pc, RESET_PC_TB);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (5) step();
        chk("t1_pc", pc, 15'd2);
        chk("t1_model_a", m_a, 16'd5);
        chk("t1_model_d", m_d, 16'd5);
        chk("t1_no_dmem", dreq_total, 0);

        forced_dwait = 3;
        run_fetches(5, 40);
        chk("t2_wr_cnt", wr_cnt, 1);
        chk("t2_wr_addr", last_wr_addr, 15'd7);
        chk("t2_wr_data", last_wr_data, 16'd6);
        chk("t2_req_cycles", last_wr_cycles, 4);

        run_fetches(7, 40);
        chk("t3_rd_cnt", rd_cnt, 1);
        chk("t3_rd_addr", last_rd_addr, 15'd3);
        chk("t3_model_d", m_d, 16'h1234);
        chk("t3_alu_y", last_alu_y, 16'h1234);

        run_fetches(9, 40);
        chk("jmp_uncond", fetch_hist[8], 15'd20);
        run_fetches(13, 40);
        chk("jgt_taken", fetch_hist[12], 15'd10);
        run_fetches(16, 40);
        chk("jgt_not_taken", fetch_hist[15], 15'd13);

        run_fetches(19, 40);
        rom[4] = 16'hE308;
        run_fetches(20, 40);
        chk("amd_jump_old_a", fetch_hist[19], 15'd4);
        chk("amd_wr_addr", last_wr_addr, 15'd4);
        chk("amd_wr_data", last_wr_data, 16'd10);
        chk("amd_ram", ram[4], 16'd10);
        chk("amd_model_a", m_a, 16'd10);
        chk("amd_model_d", m_d, 16'd10);

        dmem_hold = 1;
        begin
            int n = 0;
            while (!dmem_req && n < 20) begin step(); n++; end
        end
        chk("hold_we", dmem_we, 1'b1);
        chk("hold_addr", dmem_addr, 15'd10);
        chk("hold_data", dmem_wdata, 16'd10);
        step();
        step();
        rst_n = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        chk("rstw_dmem_req", dmem_req, 1'b0);
        chk("rstw_dmem_we", dmem_we, 1'b0);
        chk("rstw_imem_req", imem_req, 1'b0);
        chk("rstw_pc", pc, RESET_PC_TB);
        rom[0] = 16'hE308; rom[1] = 16'h7FFF; rom[2] = 16'hEA87; rom[32767] = 16'h0004;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_fetches(5, 60);
        chk("post_rst_fetch0", fetch_hist[0], RESET_PC_TB);
        chk("post_rst_wr_addr", last_wr_addr, 15'd0);
        chk("post_rst_wr_data", last_wr_data, 16'd0);
        chk("wrap_fetch1", fetch_hist[1], 15'd1);
        chk("wrap_fetch2", fetch_hist[2], 15'd2);
        chk("wrap_jmp_7fff", fetch_hist[3], 15'h7FFF);
        chk("wrap_to_zero", fetch_hist[4], 15'd0);

        for (int i = 0; i < 32768; i++) begin
            rom[i] = 16'($urandom);
            ram[i] = 16'($urandom);
        end
        max_wait = 2;
        spurious = 1;
        apply_reset();
        for (int i = 0; i < 6000; i++) begin
            if (i == 3000) apply_reset();
            step();
        end
        chk("random_progress", fetch_cnt > 100, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
Multi-cycle Hack CPU controller and register file: the initiator that drives the CPU's combinational ALU. It fetches 16-bit Hack instructions, decodes them and holds the A, D and PC registers. It presents x/y operands and the zx/nx/zy/ny/f/no controls to the ALU, consumes out/zr/ng, and sequences data-memory reads and writes over req/ack handshakes. Sits in CPU/ between instruction ROM, data RAM and the ALU instance.

Parameters:
RESET_PC, 15'h0000, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_req  output  1  instruction fetch request.
imem_addr  output  15  fetch address (= PC).
imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
imem_rdata  input  16  instruction word.
dmem_req  output  1  data access request.
dmem_we  output  1  1 = write, 0 = read; valid while dmem_req.
dmem_addr  output  15  data address.
dmem_wdata  output  16  write data.
dmem_ack  input  1  access complete; dmem_rdata valid this cycle for reads.
dmem_rdata  input  16  read data.
alu_x, alu_y  output  16  ALU operands.
alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1  ALU controls.
alu_out  input  16  ALU result (combinational, same cycle).
alu_zr, alu_ng  input  1  ALU zero / negative flags.
pc  output  15  current PC (debug).

Behaviour:
- One clock domain. Reset is asynchronous, active-low (rst_n), and clears all state immediately, including mid-transaction. On reset: PC=RESET_PC, A=0, D=0, instr=0, state=FETCH, and imem_req, dmem_req and dmem_we are all 0. alu_* controls and operands read 0.
- States: FETCH, DECODE, MREAD, EXEC, MWRITE.
- FETCH: imem_req=1, imem_addr=PC, held stable until imem_ack. On ack, latch imem_rdata into instr and go to DECODE. Ack is allowed in the first req cycle.
- DECODE:
  - instr[15]=0 (A-type): A<=instr[14:0] zero-extended, PC<=PC+1, go to FETCH.
  - C-type with a=instr[12]=1: go to MREAD.
  - Otherwise: go to EXEC.
- MREAD: dmem_req=1, we=0, addr=A[14:0]. On ack, latch M<=dmem_rdata and go to EXEC.
- EXEC: alu_x=D, alu_y = a ? M : A, {zx,nx,zy,ny,f,no}=instr[11:6].
  - Latch R<=alu_out and maddr<=A[14:0] (pre-instruction A).
  - Jump taken = (j[2]&ng) | (j[1]&zr) | (j[0]&~ng&~zr), where j=instr[2:0].
  - PC <= taken ? A[14:0] (old A) : PC+1.
  - instr[5]: A<=alu_out. instr[4]: D<=alu_out. All updates happen on the same edge, so a jump always uses the old A.
  - instr[3]=1: go to MWRITE. Else go to FETCH.
- MWRITE: dmem_req=1, we=1, addr=maddr, wdata=R. On ack, go to FETCH.
- Outside their states, req=0 and ALU controls=0. Requests never drop before ack.
- Latency with zero-wait memory:
  - A-type: 2 cycles.
  - C-type: 3 cycles, +1 if a=1, +1 if dest M.
  - Each extra wait cycle on ack adds 1.
- Arithmetic: PC+1 wraps 15'h7FFF to 0. A keeps 16 bits; addresses use A[14:0]. ALU arithmetic is the ALU's own (16-bit, wrapping).
- C-type bits 14:13 are ignored.
- A spurious ack outside the matching request state is ignored.

Decomposition:
- Package hack_pkg holds:
  - the state enum;
  - instruction field positions: IBIT_CTYPE=15, IBIT_A=12, COMP=11:6, DEST_A=5, DEST_D=4, DEST_M=3, JMP=2:0;
  - a function jump_taken(j, zr, ng).
- No sub-module is required. The ALU stays external and is instantiated alongside in the CPU top.

Test Plan:
- Reset then run 0x0005, 0xEC10 (@5; D=A), zero-wait ROM -> after 5 cycles A=5, D=5, PC=2, no dmem_req.
- 0x0007, 0xE7C8 (@7; M=D+1) with D=5 -> single write, addr=7, wdata=6, we=1, held through 3 wait cycles until ack.
- RAM[3]=0x1234, run 0x0003, 0xFC10 (@3; D=M) -> one read at addr 3, D=0x1234, alu_y=0x1234 during EXEC.
- Jumps:
  - D=5, 0x000A, 0xE301 (D;JGT) -> PC=10.
  - D=0, same program -> PC=prev+1.
  - 0xEA87 (0;JMP) with A=0x7FFF -> PC=0x7FFF; next fetch wraps to 0 after an A-type instruction.
- Dest A plus jump: A=4, instr AMD=D+1;JMP with D=9 -> PC=4 (old A), A=10, D=10, RAM[4]=10.
- Assert rst_n low while MWRITE is waiting for ack -> dmem_req drops immediately. After release: PC=RESET_PC, A=D=0, first action is FETCH at RESET_PC.
